// File: rtl/mesi_line_ctrl_if.sv
// mesi_line_ctrl_if: command, bus and response signals of the MESI line controller; slave = controller, master = front end / bus model
interface mesi_line_ctrl_if #(parameter int IDX_W = 4, parameter int TAG_W = 12);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       command;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             bus_valid;
  logic [1:0]       bus_op;
  logic [IDX_W-1:0] bus_index;
  logic [TAG_W-1:0] bus_tag;
  logic             bus_done;
  logic [1:0]       bus_hm;
  logic             snoop_valid;
  logic [1:0]       snoop_hm;
  logic             resp_valid;
  logic             resp_hit;
  logic [3:0]       resp_state;
  logic             resp_err;
  modport slave (
    input  cmd_valid, command, index, tag, bus_done, bus_hm,
    output cmd_ready, bus_valid, bus_op, bus_index, bus_tag,
           snoop_valid, snoop_hm, resp_valid, resp_hit, resp_state, resp_err
  );
  modport master (
    output cmd_valid, command, index, tag, bus_done, bus_hm,
    input  cmd_ready, bus_valid, bus_op, bus_index, bus_tag,
           snoop_valid, snoop_hm, resp_valid, resp_hit, resp_state, resp_err
  );
endinterface

// File: rtl/mesi_line_ctrl.sv
// mesi_line_ctrl: sequences one trace command through a direct-mapped MESI tag/state array and the bus
// ports: clk, reset_n (async active-low); io.slave carries cmd_valid/ready, command, index, tag,
// bus_valid/op/index/tag/done/hm, snoop_valid/hm, resp_valid/hit/state/err
module mesi_line_ctrl #(parameter int IDX_W = 4, parameter int TAG_W = 12) (
  input logic clk,
  input logic reset_n,
  mesi_line_ctrl_if.slave io
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, EVICT = 3'd2, BUS = 3'd3, UPDATE = 3'd4, CLEAR = 3'd5;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [1:0] OP_RD = 2'd0, OP_WB = 2'd1, OP_INV = 2'd2, OP_RWIM = 2'd3;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;
  logic [2:0]       state, l_next;
  logic [1:0]       st_arr [DEPTH];
  logic [TAG_W-1:0] tag_arr [DEPTH];
  logic [3:0]       cmd_r;
  logic [IDX_W-1:0] idx_r, cnt;
  logic [TAG_W-1:0] tag_r, vtag_r, cur_tag;
  logic [1:0]       op_r, new_st, hm_r, cur_st, l_op, l_st, l_hm;
  logic             hit_r, err_r, snoop_r, hit, is_rd, is_wr, is_snp, legal, wb;
  assign cur_st = st_arr[idx_r];
  assign cur_tag = tag_arr[idx_r];
  assign hit = cur_st != ST_I && cur_tag == tag_r;
  assign is_rd = cmd_r == 4'd0 || cmd_r == 4'd2;
  assign is_wr = cmd_r == 4'd1;
  assign is_snp = cmd_r inside {[4'd3:4'd6]};
  assign legal = is_rd || is_wr || is_snp;
  // snooped reads and RWIMs of a modified line must push the dirty data out first
  assign wb = cur_st == ST_M && (cmd_r == 4'd4 || cmd_r == 4'd6);
  always_comb begin
    l_next = UPDATE;
    l_op = OP_RD;
    l_st = cur_st;
    l_hm = NOHIT;
    if (is_rd && !hit) begin
      l_next = cur_st == ST_M ? EVICT : BUS;
    end else if (is_wr) begin
      l_st = ST_M;
      l_op = hit ? OP_INV : OP_RWIM;
      l_next = hit ? (cur_st == ST_S ? BUS : UPDATE) : (cur_st == ST_M ? EVICT : BUS);
    end else if (is_snp && hit) begin
      l_hm = cmd_r == 4'd5 ? NOHIT : wb ? HITM : HIT;
      l_st = cmd_r == 4'd5 ? cur_st : cmd_r == 4'd4 ? ST_S : ST_I;
      l_op = OP_WB;
      l_next = wb ? BUS : UPDATE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cmd_r <= '0;
      idx_r <= '0;
      tag_r <= '0;
      vtag_r <= '0;
      cnt <= '0;
      op_r <= OP_RD;
      new_st <= ST_I;
      hm_r <= NOHIT;
      hit_r <= 1'b0;
      err_r <= 1'b0;
      snoop_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        st_arr[i] <= ST_I;
        tag_arr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (io.cmd_valid) begin
          cmd_r <= io.command;
          idx_r <= io.index;
          tag_r <= io.tag;
          cnt <= '0;
          if (io.command == 4'd8) begin
            state <= CLEAR;
            new_st <= ST_I;
            hit_r <= 1'b0;
            err_r <= 1'b0;
            snoop_r <= 1'b0;
          end else state <= LOOKUP;
        end
        LOOKUP: begin
          hit_r <= hit;
          err_r <= !legal;
          snoop_r <= is_snp;
          new_st <= l_st;
          hm_r <= l_hm;
          op_r <= l_op;
          vtag_r <= cur_tag;
          state <= legal ? l_next : UPDATE;
        end
        EVICT: if (io.bus_done) state <= BUS;
        BUS: if (io.bus_done) begin
          state <= UPDATE;
          if (op_r == OP_RD) new_st <= io.bus_hm != NOHIT ? ST_S : ST_E;
        end
        UPDATE: begin
          if (!err_r) begin
            st_arr[idx_r] <= new_st;
            if (!snoop_r) tag_arr[idx_r] <= tag_r;
          end
          state <= IDLE;
        end
        CLEAR: begin
          st_arr[cnt] <= ST_I;
          cnt <= cnt + 1'b1;
          if (&cnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign io.cmd_ready = state == IDLE;
  assign io.bus_valid = state == EVICT || state == BUS;
  assign io.bus_op = state == EVICT ? OP_WB : op_r;
  assign io.bus_index = idx_r;
  assign io.bus_tag = state == EVICT ? vtag_r : tag_r;
  assign io.resp_valid = state == UPDATE || (state == CLEAR && &cnt);
  assign io.resp_hit = io.resp_valid && hit_r;
  assign io.resp_err = io.resp_valid && err_r;
  assign io.resp_state = 4'b0001 << new_st;
  assign io.snoop_valid = state == UPDATE && snoop_r;
  assign io.snoop_hm = io.snoop_valid ? hm_r : NOHIT;
endmodule

// File: tb/tb_mesi_line_ctrl.sv
// tb_mesi_line_ctrl: directed scoreboard bench for mesi_line_ctrl with a bus responder and response monitor
module tb_mesi_line_ctrl;
  typedef struct packed {logic hit; logic [3:0] st; logic err; logic sv; logic [1:0] hm;} resp_t;
  typedef struct packed {logic [1:0] op; logic [3:0] idx; logic [11:0] tag; logic [1:0] hm;} bus_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic bus_hang = 1'b0;
  int total = 0;
  int bad = 0;
  int bus_lat = 0;
  int lat;
  resp_t exp_q[$];
  bus_t bus_q[$];
  resp_t me;
  bus_t be;
  mesi_line_ctrl_if io();
  mesi_line_ctrl dut (.clk(clk), .reset_n(reset_n), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  function automatic resp_t r(input logic h, input logic [3:0] s, input logic e, input logic sv, input logic [1:0] hm);
    r = '{h, s, e, sv, hm};
  endfunction
  function automatic bus_t b(input logic [1:0] op, input logic [3:0] idx, input logic [11:0] tag, input logic [1:0] hm);
    b = '{op, idx, tag, hm};
  endfunction
  always @(negedge clk) begin
    if (reset_n && io.resp_valid) begin
      if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
      else begin
        me = exp_q.pop_front();
        check("resp_hit", io.resp_hit, me.hit);
        check("resp_state", io.resp_state, me.st);
        check("resp_err", io.resp_err, me.err);
        check("snoop_valid", io.snoop_valid, me.sv);
        check("snoop_hm", io.snoop_hm, me.hm);
      end
    end
  end
  initial begin
    io.bus_done = 1'b0;
    io.bus_hm = 2'd0;
    forever begin
      @(negedge clk);
      if (reset_n && io.bus_valid && !bus_hang) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus", 1, 0);
          be = b(io.bus_op, io.bus_index, io.bus_tag, 2'd0);
        end else be = bus_q.pop_front();
        check("bus_op", io.bus_op, be.op);
        check("bus_index", io.bus_index, be.idx);
        check("bus_tag", io.bus_tag, be.tag);
        for (int i = 0; i < bus_lat; i++) begin
          @(negedge clk);
          check("bus_hold", {io.bus_valid, io.bus_op, io.bus_tag}, {1'b1, be.op, be.tag});
        end
        io.bus_done = 1'b1;
        io.bus_hm = be.hm;
        @(negedge clk);
        io.bus_done = 1'b0;
        io.bus_hm = 2'd0;
        bus_lat = (bus_lat + 1) % 3;
      end
    end
  end
  task automatic issue(input logic [3:0] c, input logic [3:0] idx, input logic [11:0] t, input resp_t e, output int l);
    int n;
    n = 0;
    while (!io.cmd_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_q.push_back(e);
    io.command = c;
    io.index = idx;
    io.tag = t;
    io.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!io.resp_valid && l < 200);
    if (!io.resp_valid) check("resp_timeout", 0, 1);
    check("ready_busy", io.cmd_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after", io.cmd_ready, 1);
  endtask
  initial begin
    int n;
    io.cmd_valid = 1'b0;
    io.command = 4'd0;
    io.index = 4'd0;
    io.tag = 12'd0;
    #12;
    check("rst_ready", io.cmd_ready, 1);
    check("rst_outs", {io.bus_valid, io.bus_op, io.bus_index, io.bus_tag, io.resp_valid, io.resp_hit, io.resp_err, io.snoop_valid, io.snoop_hm}, 0);
    check("rst_state", io.resp_state, 4'b0001);
    @(negedge clk);
    reset_n = 1'b1;
    bus_q.push_back(b(2'd0, 4'd3, 12'h012, 2'd0));
    issue(4'd0, 4'd3, 12'h012, r(0, 4'b0100, 0, 0, 0), lat);
    issue(4'd0, 4'd3, 12'h012, r(1, 4'b0100, 0, 0, 0), lat);
    check("hit_lat", lat, 2);
    issue(4'd1, 4'd3, 12'h012, r(1, 4'b1000, 0, 0, 0), lat);
    check("wr_hit_lat", lat, 2);
    bus_q.push_back(b(2'd1, 4'd3, 12'h012, 2'd0));
    bus_q.push_back(b(2'd0, 4'd3, 12'h034, 2'd1));
    issue(4'd0, 4'd3, 12'h034, r(0, 4'b0010, 0, 0, 0), lat);
    bus_q.push_back(b(2'd2, 4'd3, 12'h034, 2'd0));
    issue(4'd1, 4'd3, 12'h034, r(1, 4'b1000, 0, 0, 0), lat);
    bus_q.push_back(b(2'd1, 4'd3, 12'h034, 2'd0));
    issue(4'd4, 4'd3, 12'h034, r(1, 4'b0010, 0, 1, 2), lat);
    issue(4'd6, 4'd3, 12'h034, r(1, 4'b0001, 0, 1, 1), lat);
    issue(4'd3, 4'd3, 12'h034, r(0, 4'b0001, 0, 1, 0), lat);
    bus_q.push_back(b(2'd3, 4'd5, 12'h055, 2'd0));
    issue(4'd1, 4'd5, 12'h055, r(0, 4'b1000, 0, 0, 0), lat);
    issue(4'd11, 4'd5, 12'h055, r(1, 4'b1000, 1, 0, 0), lat);
    issue(4'd5, 4'd5, 12'h055, r(1, 4'b1000, 0, 1, 0), lat);
    issue(4'd2, 4'd5, 12'h055, r(1, 4'b1000, 0, 0, 0), lat);
    bus_q.push_back(b(2'd1, 4'd5, 12'h055, 2'd0));
    issue(4'd6, 4'd5, 12'h055, r(1, 4'b0001, 0, 1, 2), lat);
    bus_q.push_back(b(2'd0, 4'd7, 12'h077, 2'd0));
    issue(4'd2, 4'd7, 12'h077, r(0, 4'b0100, 0, 0, 0), lat);
    issue(4'd4, 4'd7, 12'h077, r(1, 4'b0010, 0, 1, 1), lat);
    issue(4'd3, 4'd7, 12'h078, r(0, 4'b0010, 0, 1, 0), lat);
    bus_q.push_back(b(2'd3, 4'd12, 12'h0cc, 2'd0));
    issue(4'd1, 4'd12, 12'h0cc, r(0, 4'b1000, 0, 0, 0), lat);
    issue(4'd8, 4'd0, 12'h000, r(0, 4'b0001, 0, 0, 0), lat);
    check("clear_lat", lat, 16);
    bus_q.push_back(b(2'd0, 4'd7, 12'h077, 2'd0));
    issue(4'd0, 4'd7, 12'h077, r(0, 4'b0100, 0, 0, 0), lat);
    bus_q.push_back(b(2'd3, 4'd12, 12'h0cc, 2'd0));
    issue(4'd1, 4'd12, 12'h0cc, r(0, 4'b1000, 0, 0, 0), lat);
    bus_hang = 1'b1;
    io.command = 4'd0;
    io.index = 4'd9;
    io.tag = 12'h099;
    io.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    n = 0;
    while (!io.bus_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midop_bus_up", io.bus_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midop_bus_drop", io.bus_valid, 0);
    check("midop_ready", io.cmd_ready, 1);
    check("midop_no_resp", io.resp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_hang = 1'b0;
    issue(4'd3, 4'd9, 12'h099, r(0, 4'b0001, 0, 1, 0), lat);
    issue(4'd3, 4'd12, 12'h0cc, r(0, 4'b0001, 0, 1, 0), lat);
    repeat (3) @(negedge clk);
    check("resp_q_empty", exp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mesi_line_ctrl.md
# mesi_line_ctrl

Sequencing controller wrapped around the MESI next-state function of the L2 cache model. Accepts one trace command at a time over a valid/ready handshake, looks up a direct-mapped tag/state array, issues bus operations (eviction writeback, READ, RWIM, INVALIDATE) and waits for completion. It then applies the MESI transition, writes the line back, and reports hit/state plus the snoop result it drives. Sits between the trace front end and the bus model.

## Interface
- IDX_W, 4, line index width; array depth 2^IDX_W
- TAG_W, 12, tag width
- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  controller idle, command accepted when VALID&&READY
- COMMAND  in  4  0 rd data, 1 wr, 2 rd instr, 3 snoop inval, 4 snoop rd, 5 snoop wr, 6 snoop RWIM, 8 clear all
- INDEX  in  IDX_W  line index
- TAG  in  TAG_W  address tag
- BUS_VALID  out  1  bus op request, held until BUS_DONE
- BUS_OP  out  2  0 READ, 1 WRITE(back), 2 INVALIDATE, 3 RWIM
- BUS_INDEX / BUS_TAG  out  IDX_W / TAG_W  line address of bus op
- BUS_DONE  in  1  bus op complete (one-cycle pulse)
- BUS_HM  in  2  other caches' snoop result for READ, sampled with BUS_DONE: 0 NOHIT, 1 HIT, 2 HITM
- SNOOP_VALID  out  1  one-cycle pulse, SNOOP_HM valid
- SNOOP_HM  out  2  our result for snoop commands 3-6
- RESP_VALID  out  1  one-cycle pulse, command finished
- RESP_HIT  out  1  lookup hit (state!=I and tag match)
- RESP_STATE  out  4  final line state, one-hot: I=0001, S=0010, E=0100, M=1000
- RESP_ERR  out  1  illegal command (7, 9-15)

## Operation
- FSM: IDLE, LOOKUP, EVICT, BUS, UPDATE, CLEAR.
- IDLE: CMD_READY=1; on accept latch COMMAND/INDEX/TAG; cmd 8 -> CLEAR, else -> LOOKUP.
- LOOKUP: read state/tag at INDEX, compute hit. Illegal -> UPDATE with ERR, no write.
- Read (0,2): hit -> UPDATE, state unchanged. Miss: victim M with other tag -> EVICT (WRITE of old tag) then BUS READ; else BUS READ. Next state S if BUS_HM is HIT/HITM, E if NOHIT; tag written.
- Write (1): M/E hit -> M, no bus. S hit -> INVALIDATE, then M. Miss -> (EVICT if victim M) RWIM, then M.
- Snoop (3-6), tag miss or I: SNOOP_HM=NOHIT, no change, no bus.
- Snoop hit: 3: S->I, HIT. 4: M->S with WRITE writeback, HITM; E/S->S, HIT. 5: no change, NOHIT. 6: M->I with WRITE, HITM; E/S->I, HIT.
- BUS: BUS_VALID=1, BUS_OP/INDEX/TAG stable until BUS_DONE sampled 1; then next bus op or UPDATE.
- UPDATE: write array, RESP_VALID=1 (plus SNOOP_VALID for 3-6), -> IDLE.
- CLEAR: sweep counter 0..2^IDX_W-1, one entry set to I per cycle; RESP_VALID on final entry cycle, RESP_STATE=I.

## Timing
- Reset (async assert): FSM IDLE, all array entries I, tags 0; CMD_READY=1, every other output 0, RESP_STATE=0001.
- Reset mid-operation: pending op dropped, no response, BUS_VALID deasserts immediately.
- Accept at edge N: LOOKUP cycle N+1; no-bus command RESP_VALID in cycle N+2; CMD_READY=1 again in cycle N+3.
- Each bus op adds cycles from BUS_VALID rise to BUS_DONE (min 1); BUS_DONE outside BUS ignored.
- Eviction then READ: BUS_VALID stays high across both ops, BUS_OP changes the cycle after first BUS_DONE.
- CMD_READY=0 from accept until the cycle after RESP_VALID; CMD_VALID ignored while busy.
- CLEAR: RESP_VALID 2^IDX_W cycles after accept.

## Test plan
- Reset, cmd 0 idx 3 tag 0x12, BUS_HM=NOHIT -> BUS_OP READ, then RESP_HIT=0, RESP_STATE=0100; repeat -> RESP_HIT=1, 0100, no bus op, RESP_VALID 2 cycles after accept.
- Line idx 3 in E, cmd 1 -> state 1000, no bus; then cmd 0 idx 3 tag 0x34 -> WRITE tag 0x12 then READ tag 0x34, BUS_HM=HIT -> 0010.
- Line in S, cmd 1 -> INVALIDATE then 1000; cmd 4 same line -> WRITE, SNOOP_HM=2, state 0010.
- Cmd 6 on S line -> SNOOP_HM=1, state 0001; cmd 3 on I line -> SNOOP_HM=0; cmd 11 -> RESP_ERR=1, array unchanged.
- Fill lines, cmd 8 with IDX_W=4 -> RESP_VALID 16 cycles after accept, all reads then miss.
- RESET_N low while BUS_VALID=1 -> BUS_VALID=0 same cycle, CMD_READY=1, line reads I.
